lzc_normalizer: RTL and testbench
=================================

# lzc_normalizer

Pipelined left-normalizer that sits directly downstream of the leading-zero counter. It accepts a WIDTH-bit operand over a valid/ready handshake and counts its leading zeros with an internal `lzc` instance (MODE=1). It shifts the operand left so that its MSB is 1 and emits the normalized value, the shift amount and a zero flag. It is the normalization stage in front of FPU rounding and fixed-point scaling datapaths.

## Interface
- `WIDTH`, default 32: operand width. Must be ≥ 2; elaboration fails otherwise.
- `CNT_W`, default `$clog2(WIDTH)`: shift-amount width. Derived; do not override.
- `clk_i`  in  1: clock. All state changes on the rising edge.
- `rst_ni`  in  1: reset. Asynchronous, active-low.
- `flush_i`  in  1: synchronous pipeline clear.
- `in_valid_i`  in  1: input operand valid.
- `in_ready_o`  out  1: block can accept an operand.
- `in_data_i`  in  WIDTH: operand.
- `out_valid_o`  out  1: result valid.
- `out_ready_i`  in  1: consumer accepts result.
- `out_data_o`  out  WIDTH: normalized operand.
- `out_shamt_o`  out  CNT_W: number of leading zeros removed.
- `out_zero_o`  out  1: operand was all zeros.

## Operation
- An input transfer occurs when `in_valid_i & in_ready_o`. An output transfer occurs when `out_valid_o & out_ready_i`.
- Count: leading zeros of `in_data_i` via `lzc` with WIDTH=WIDTH, MODE=1. `empty_o` of `lzc` drives the zero flag.
- Shift: `out_data_o = operand << cnt`, with zeros filling from the LSB. For a nonzero operand, `out_data_o[WIDTH-1]` is always 1.
- Zero operand: `out_data_o = 0`, `out_shamt_o = 0`, `out_zero_o = 1`. The `lzc` count is ignored in this case.
- Non-power-of-two WIDTH is supported. The maximum shift is WIDTH-1, which fits in CNT_W.
- Each pipeline stage holds one register slot (valid bit plus payload).
  - A stage loads when it is empty or when its content leaves in the same cycle.
  - `ready` of a stage = `~valid_q | downstream_ready`. `in_ready_o` is the ready of the first stage.
- Stall: while `out_valid_o & ~out_ready_i`, all outputs hold stable and no stage overwrites held data.
- Flush: `flush_i=1` clears every valid bit on the next edge.
  - `in_ready_o` is forced to 0 during the flush cycle, so no operand is accepted.
  - Payload registers are left unchanged.
- Ordering: results leave strictly in acceptance order. The block never drops or duplicates an operand.

## Timing
- Reset values: all valid bits 0. `out_valid_o=0`, `out_data_o=0`, `out_shamt_o=0`, `out_zero_o=0`. `in_ready_o=1` once reset is released and `flush_i=0`.
- Reset asserted mid-operation discards all in-flight operands immediately, without waiting for a clock edge.
- Latency: see Configuration (1 or 2 cycles from input transfer to `out_valid_o`).
- Throughput: one operand per cycle while `out_ready_i=1`. Full throughput needs no bubble cycles.
- `in_ready_o` depends combinationally on `out_ready_i` and `flush_i`. There is no combinational path from `in_valid_i` or `in_data_i` to `in_ready_o`.
- Output payload comes from registers. There is no combinational path from the input to the output.
- Flush coinciding with an output transfer: the transfer completes normally in that cycle, and the stage is empty afterwards.

## Configuration
- Macro: `LZC_NORMALIZER_PIPE_EN`.
- Defined:
  - Two stages. Stage 1 registers the operand, count and zero flag; stage 2 registers the shifted result.
  - Latency 2 cycles; up to 2 operands in flight.
- Undefined:
  - Single stage. Count and shift are combinational in front of one register.
  - Latency 1 cycle; 1 operand in flight.
- Both variants produce identical result sequences. Only latency and in-flight capacity differ.

## Test plan
(WIDTH=8, `out_ready_i=1` unless stated; L = configured latency.)
- Basic: `8'b0001_0110` → after L cycles `out_data_o=8'b1011_0000`, `out_shamt_o=3`, `out_zero_o=0`.
- Extremes:
  - `8'h80` → data `8'h80`, shamt 0.
  - `8'h01` → data `8'h80`, shamt 7.
  - `8'h00` → data 0, shamt 0, zero 1.
- Back-to-back stream `8'h01, 8'h02, 8'h04, 8'h08` → shamt 7, 6, 5, 4 on consecutive cycles, all data `8'h80`.
- Back-pressure:
  - Hold `out_ready_i=0` for 3 cycles with a continuous input stream.
  - Outputs stay constant; `in_ready_o` drops once L operands are held.
  - After release, every operand appears in order with no loss.
- Flush: assert `flush_i` with L operands in flight → next cycle `out_valid_o=0`, and a later operand `8'h10` yields shamt 3.
- Reset: deassert `rst_ni` mid-stream → `out_valid_o`, data, shamt and zero read 0 before the next clock edge; after release, `in_ready_o=1`.

Source files
------------

// File: rtl/lzc_normalizer.sv
// Pipelined left-normalizer: leading-zero count plus left shift behind a valid/ready handshake.
// Optional macro LZC_NORMALIZER_PIPE_EN selects the two-stage variant; default is single-stage.

module lzc #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned MODE  = 0,
  parameter int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             empty_o
);

  // MODE=1 counts from the MSB; descending scan lets the nearest set bit win.
  always_comb begin
    // NOTE: default assignment before the loop keeps this purely combinational (no latch).
    cnt_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (MODE != 0) begin
        if (in_i[WIDTH-1-i]) cnt_o = CNT_W'(i);
      end else begin
        if (in_i[i]) cnt_o = CNT_W'(i);
      end
    end
  end

  assign empty_o = ~|in_i;

endmodule

module lzc_normalizer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CNT_W-1:0] out_shamt_o,
  output logic             out_zero_o
);

  if (WIDTH < 2) begin : g_width_check
    $error("lzc_normalizer: WIDTH must be at least 2");
  end

  logic [CNT_W-1:0] lz_cnt;
  logic             lz_empty;

  lzc #(
    .WIDTH (WIDTH),
    .MODE  (1),
    .CNT_W (CNT_W)
  ) u_lzc (
    .in_i    (in_data_i),
    .cnt_o   (lz_cnt),
    .empty_o (lz_empty)
  );

`ifdef LZC_NORMALIZER_PIPE_EN

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_data_q;
  logic [CNT_W-1:0] s1_cnt_q;
  logic             s1_zero_q;
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_data_q;
  logic [CNT_W-1:0] s2_shamt_q;
  logic             s2_zero_q;

  logic s2_ready;
  logic s1_ready;
  logic accept;
  logic s1_move;

  assign s2_ready   = ~s2_valid_q | out_ready_i;
  assign s1_ready   = ~s1_valid_q | s2_ready;
  assign in_ready_o = s1_ready & ~flush_i;
  assign accept     = in_valid_i & in_ready_o;
  assign s1_move    = s1_valid_q & s2_ready & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: payload is reset along with the valid bits so every output reads 0 while in reset.
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_cnt_q   <= '0;
      s1_zero_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_shamt_q <= '0;
      s2_zero_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so both stages sample pre-edge values of each other.
      if (flush_i) begin
        s1_valid_q <= 1'b0;
        s2_valid_q <= 1'b0;
      end else begin
        if (s1_ready) s1_valid_q <= in_valid_i;
        if (s2_ready) s2_valid_q <= s1_valid_q;
      end
      if (accept) begin
        s1_data_q <= in_data_i;
        s1_cnt_q  <= lz_cnt;
        s1_zero_q <= lz_empty;
      end
      // A zero operand discards the count and forces a clean all-zero result.
      if (s1_move) begin
        s2_data_q  <= s1_zero_q ? '0 : (s1_data_q << s1_cnt_q);
        s2_shamt_q <= s1_zero_q ? '0 : s1_cnt_q;
        s2_zero_q  <= s1_zero_q;
      end
    end
  end

  assign out_valid_o = s2_valid_q;
  assign out_data_o  = s2_data_q;
  assign out_shamt_o = s2_shamt_q;
  assign out_zero_o  = s2_zero_q;

`else

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] shamt_q;
  logic             zero_q;

  logic             stage_ready;
  logic             accept;
  logic [WIDTH-1:0] norm_data;
  logic [CNT_W-1:0] norm_shamt;

  assign stage_ready = ~valid_q | out_ready_i;
  assign in_ready_o  = stage_ready & ~flush_i;
  assign accept      = in_valid_i & in_ready_o;

  // A zero operand discards the count and forces a clean all-zero result.
  assign norm_data  = lz_empty ? '0 : (in_data_i << lz_cnt);
  assign norm_shamt = lz_empty ? '0 : lz_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: payload is reset along with the valid bit so every output reads 0 while in reset.
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so the register updates only at the clock edge.
      if (flush_i) begin
        valid_q <= 1'b0;
      end else if (stage_ready) begin
        valid_q <= in_valid_i;
      end
      if (accept) begin
        data_q  <= norm_data;
        shamt_q <= norm_shamt;
        zero_q  <= lz_empty;
      end
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_shamt_o = shamt_q;
  assign out_zero_o  = zero_q;

`endif

endmodule

// File: tb/tb_lzc_normalizer.sv
// Scoreboard bench for lzc_normalizer (WIDTH=8): directed test-plan cases plus randomized traffic
// with random back-pressure and flushes, checked against an arithmetic reference model.

module tb_lzc_normalizer;

`ifdef LZC_NORMALIZER_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [7:0] data;
    logic [2:0] shamt;
    logic       zero;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_shamt;
  logic       out_zero;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  int   acc_cnt = 0;
  int   run = 0;
  int   max_run = 0;
  bit   rand_ready = 0;

  lzc_normalizer #(.WIDTH(8)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_shamt_o (out_shamt),
    .out_zero_o  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: double the value until its top bit is set, counting the doublings.
  function automatic exp_t model(input logic [7:0] d);
    exp_t e;
    int   v;
    int   s;
    if (d == 8'h00) begin
      e.data = 8'h00; e.shamt = 3'd0; e.zero = 1'b1;
    end else begin
      v = int'(d);
      s = 0;
      while (v < 128) begin
        v = v * 2;
        s = s + 1;
      end
      e.data = 8'(v); e.shamt = 3'(s); e.zero = 1'b0;
    end
    return e;
  endfunction

  // Monitor: mid-cycle, compare any presented result against the queue head; pop on transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      run = 0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          check("out_data", 32'(out_data), 32'(sb[0].data));
          check("out_shamt", 32'(out_shamt), 32'(sb[0].shamt));
          check("out_zero", 32'(out_zero), 32'(sb[0].zero));
          if (out_ready) void'(sb.pop_front());
        end
      end
      if (out_valid && out_ready) run++;
      else run = 0;
      if (run > max_run) max_run = run;
      if (flush) sb.delete();
      if (in_valid && in_ready) begin
        sb.push_back(model(in_data));
        acc_cnt++;
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        check("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      cyc();
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    cyc();
  endtask

  task automatic measure(input string name, input logic [7:0] d);
    int n = 1;
    send(d);
    while (!out_valid && n < 20) begin
      cyc();
      n++;
    end
    check(name, 32'(n), 32'(LAT));
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_shamt", 32'(out_shamt), 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    cyc();

    measure("lat_basic", 8'b0001_0110);
    measure("lat_msb", 8'h80);
    measure("lat_lsb", 8'h01);
    measure("lat_zero", 8'h00);

    // Back-to-back stream must leave on consecutive cycles.
    max_run = 0;
    send(8'h01); send(8'h02); send(8'h04); send(8'h08);
    drain();
    check("b2b_consecutive", 32'(max_run >= 4), 32'd1);

    // Back-pressure: ready low for 3 cycles while the source keeps offering.
    begin
      int a0;
      a0 = acc_cnt;
      out_ready = 1'b0;
      fork
        begin
          for (int i = 0; i < 6; i++) send(8'(8'h03 << i));
        end
        begin
          repeat (3) cyc();
          check("bp_in_ready_low", 32'(in_ready), 32'd0);
          check("bp_accepted", 32'(acc_cnt - a0), 32'(LAT));
          out_ready = 1'b1;
        end
      join
      drain();
      check("bp_all_delivered", 32'(acc_cnt - a0), 32'd6);
    end

    // Flush with LAT operands held in flight.
    out_ready = 1'b0;
    for (int i = 0; i < LAT; i++) send(8'(8'h20 >> i));
    flush = 1'b1;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    cyc();
    flush = 1'b0;
    out_ready = 1'b1;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    measure("lat_after_flush", 8'h10);

    // Randomized traffic with random back-pressure and occasional flushes.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      d = d >> $urandom_range(0, 8);
      send(d);
      if ($urandom_range(0, 5) == 0) cyc();
      if ($urandom_range(0, 40) == 0) begin
        flush = 1'b1;
        cyc();
        flush = 1'b0;
      end
    end
    drain();
    rand_ready = 1'b0;
    cyc();
    out_ready = 1'b1;

    // Asynchronous reset in the middle of a stalled stream.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h01;
    repeat (3) cyc();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_out_shamt", 32'(out_shamt), 32'd0);
    check("mid_rst_out_zero", 32'(out_zero), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    cyc();
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    measure("lat_after_rst", 8'h16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
